// File: rtl/rr_arbiter_ctrl_if.sv
// ============================================================================
// Module : rr_arbiter_ctrl_if
// Brief  : Request/grant bundle between requesters and the round-robin arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_ctrl_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic            timeout;

    // Requester side
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout
    );

    // Arbiter side
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout
    );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_ctrl.sv
// ============================================================================
// Module : rr_arbiter_ctrl
// Brief  : Round-robin arbiter sharing one single-user unit among N requesters.
//          Optional forced release after MAX_HOLD cycles: define ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter_ctrl #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    rr_arbiter_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [ID_W-1:0] c_last_id = ID_W'(N - 1);

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [ID_W-1:0] r_gnt_id;
    logic            r_gnt_valid;
    logic            r_timeout;
    logic [ID_W-1:0] r_ptr;

    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_pick;
    logic            w_any;
    logic            w_release;
    logic            w_force;
    logic [ID_W-1:0] w_ptr_next;

    // First requester at or after the priority pointer, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N);
            if (!w_any && bus.req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_release  = bus.done[r_gnt_id] | ~bus.req[r_gnt_id];
    assign w_ptr_next = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] c_hold_max  = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] r_hold_cnt;

    assign w_force = (r_hold_cnt == c_hold_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if (r_state == S_IDLE || w_release || w_force) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != c_hold_max) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_cfg;

    assign w_force      = 1'b0;
    assign w_unused_cfg = ^{32'(MAX_HOLD), 32'(CNT_W)};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_GRANT;
                        r_gnt       <= N'(1) << w_pick;
                        r_gnt_id    <= w_pick;
                        r_gnt_valid <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // A normal release wins over a coincident forced one.
                    if (w_release || w_force) begin
                        r_state     <= S_IDLE;
                        r_gnt       <= '0;
                        r_gnt_id    <= '0;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_timeout   <= ~w_release;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_gnt       <= '0;
                    r_gnt_id    <= '0;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_ctrl.sv
// ============================================================================
// Module : tb_rr_arbiter_ctrl
// Brief  : Scoreboard bench for rr_arbiter_ctrl against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_ctrl;

    localparam int N        = 4;
    localparam int ID_W     = 2;
    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic [ID_W-1:0] id;
        logic            valid;
        logic            to;
    } exp_t;

    logic clk;
    logic reset;

    rr_arbiter_ctrl_if #(.N(N), .ID_W(ID_W)) bus ();

    rr_arbiter_ctrl #(
        .N        (N),
        .ID_W     (ID_W),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Model state: owner index (-1 when none), priority pointer, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    function automatic exp_t model_out(input bit to);
        exp_t e;
        e.gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.id    = (m_owner >= 0) ? ID_W'(m_owner) : '0;
        e.valid = (m_owner >= 0);
        e.to    = to;
        return e;
    endfunction

    task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] dn,
                              input logic rst_n, output exp_t e);
        bit to;
        to = 1'b0;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && rq[idx]) begin
                    m_owner = idx;
                    m_hold  = 1;
                end
            end
        end else if (dn[m_owner] || !rq[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (TIMEOUT_ON && m_hold >= MAX_HOLD) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            to      = 1'b1;
        end else begin
            m_hold++;
        end
        e = model_out(to);
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next
    // rising edge must produce.
    task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] dn,
                         input logic rst_n);
        exp_t e;
        @(negedge clk);
        reset    = rst_n;
        bus.req  = rq;
        bus.done = dn;
        model_step(rq, dn, rst_n, e);
        if (!rst_n) begin
            #1;
            total++;
            if (bus.gnt !== '0 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== '0
                || bus.timeout !== 1'b0) begin
                bad++;
                $display("FAIL async_reset: gnt=%b valid=%b id=%0d to=%b required all zero",
                         bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout);
            end
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [N-1:0] owner_done();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    // Monitor: every rising edge consumes one expectation, if one is pending.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e       = exp_q.pop_front();
                a.gnt   = bus.gnt;
                a.id    = bus.gnt_id;
                a.valid = bus.gnt_valid;
                a.to    = bus.timeout;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs @%0t: gnt=%b id=%0d valid=%b to=%b required gnt=%b id=%0d valid=%b to=%b",
                             $time, a.gnt, a.id, a.valid, a.to, e.gnt, e.id, e.valid, e.to);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] dn;
        reset    = 1'b0;
        bus.req  = '0;
        bus.done = '0;

        // Reset held with all requests up, then release: requester 0 first.
        cycle(4'b1111, 4'b0000, 1'b0);
        cycle(4'b1111, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b0000, 1'b1);

        // Alternating pair served in turn with done pulses.
        cycle(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 12; i++) cycle(4'b1010, owner_done(), 1'b1);

        // All requesting: pointer walks through 3 and wraps to 0.
        for (int i = 0; i < 12; i++) cycle(4'b1111, owner_done(), 1'b1);

        // Owner 2 ignores foreign done, then drops its request.
        cycle(4'b0000, 4'b0000, 1'b0);
        cycle(4'b0100, 4'b0000, 1'b1);
        cycle(4'b0100, 4'b0001, 1'b1);
        cycle(4'b0101, 4'b1001, 1'b1);
        cycle(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) cycle(4'b1001, 4'b0000, 1'b1);

        // Done and request drop together: a single release.
        cycle(4'b1001, owner_done(), 1'b1);
        cycle(4'b0000, 4'b0000, 1'b1);

        // Persistent single requester without done.
        for (int i = 0; i < 25; i++) cycle(4'b0001, 4'b0000, 1'b1);

        // Reset asserted mid-grant, then lowest index first after release.
        cycle(4'b1100, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b1100, 4'b0000, 1'b1);

        // Randomised traffic with sticky requests and occasional resets.
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            dn = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) dn[b] = 1'b1;
            end
            cycle(rq, dn, ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
        end

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
